// File: rtl/mmu_ctxload.sv
// Context-switch sequencer: shadow store of 2^CTXW eight-entry page tables streamed into the MMU
// over a write/ack handshake. Define MMU_CTXLOAD_FAULTCAP_EN to build in sticky page-fault capture.
module mmu_ctxload #(
  parameter int CTXW = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_we,
  input  logic [CTXW+2:0] i_waddr,
  input  logic [7:0]      i_wdata,
  output logic            o_werr,
  input  logic            i_start,
  input  logic [CTXW-1:0] i_ctx,
  output logic            o_busy,
  output logic            o_done,
  output logic [CTXW-1:0] o_cur_ctx,
  output logic            o_pte_we,
  output logic [2:0]      o_pte_idx,
  output logic [7:0]      o_pte_data,
  input  logic            i_pte_ack,
  input  logic            i_pgfault_n,
  input  logic            i_vstb,
  input  logic [2:0]      i_vaddr,
  input  logic            i_fault_clr,
  output logic            o_fault,
  output logic [2:0]      o_fault_page,
  output logic [CTXW-1:0] o_fault_ctx
);

  localparam int NENT = (32'd1 << CTXW) * 32'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [7:0]      shadow_r [0:NENT-1];
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            werr_r;
  logic            pte_we_r, pte_we_s;
  logic [2:0]      pte_idx_r, pte_idx_s;
  logic [7:0]      pte_data_r, pte_data_s;
  logic [CTXW-1:0] cur_ctx_r, cur_ctx_s;
  logic [CTXW-1:0] ld_ctx_r, ld_ctx_s;

  // Next-state and next-output decode for the load sequencer
  always_comb begin
    state_s    = state_r;
    pte_we_s   = pte_we_r;
    pte_idx_s  = pte_idx_r;
    pte_data_s = pte_data_r;
    done_s     = 1'b0;
    cur_ctx_s  = cur_ctx_r;
    ld_ctx_s   = ld_ctx_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_s    = ST_LOAD;
          ld_ctx_s   = i_ctx;
          pte_idx_s  = 3'd0;
          pte_data_s = shadow_r[{i_ctx, 3'd0}];
          pte_we_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (i_pte_ack) begin
          if (pte_idx_r == 3'd7) begin
            pte_we_s  = 1'b0;
            cur_ctx_s = ld_ctx_r;
            done_s    = 1'b1;
            state_s   = ST_DONE;
          end else begin
            pte_idx_s  = pte_idx_r + 3'd1;
            pte_data_s = shadow_r[{ld_ctx_r, pte_idx_s}];
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: begin
        state_s  = ST_IDLE;
        pte_we_s = 1'b0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // Sequencer registers and shadow store; shadow writes are only accepted while idle
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      werr_r     <= 1'b0;
      pte_we_r   <= 1'b0;
      pte_idx_r  <= 3'd0;
      pte_data_r <= 8'h00;
      cur_ctx_r  <= {CTXW{1'b0}};
      ld_ctx_r   <= {CTXW{1'b0}};
      for (int i = 0; i < NENT; i++) begin
        shadow_r[i] <= 8'h00;
      end
    end else begin
      state_r    <= state_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      werr_r     <= i_we && busy_r;
      pte_we_r   <= pte_we_s;
      pte_idx_r  <= pte_idx_s;
      pte_data_r <= pte_data_s;
      cur_ctx_r  <= cur_ctx_s;
      ld_ctx_r   <= ld_ctx_s;
      if (i_we && !busy_r) begin
        shadow_r[i_waddr] <= i_wdata;
      end
    end
  end

  assign o_busy     = busy_r;
  assign o_done     = done_r;
  assign o_werr     = werr_r;
  assign o_pte_we   = pte_we_r;
  assign o_pte_idx  = pte_idx_r;
  assign o_pte_data = pte_data_r;
  assign o_cur_ctx  = cur_ctx_r;

`ifdef MMU_CTXLOAD_FAULTCAP_EN
  logic            fault_r;
  logic [2:0]      fault_page_r;
  logic [CTXW-1:0] fault_ctx_r;

  // Sticky fault capture: first fault is kept; clear beats a new fault only once one is held
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fault_r      <= 1'b0;
      fault_page_r <= 3'd0;
      fault_ctx_r  <= {CTXW{1'b0}};
    end else if (fault_r && i_fault_clr) begin
      fault_r <= 1'b0;
    end else if (!fault_r && i_vstb && !i_pgfault_n) begin
      fault_r      <= 1'b1;
      fault_page_r <= i_vaddr;
      fault_ctx_r  <= cur_ctx_r;
    end else begin
      fault_r <= fault_r;
    end
  end

  assign o_fault      = fault_r;
  assign o_fault_page = fault_page_r;
  assign o_fault_ctx  = fault_ctx_r;
`else
  logic unused_fault_s;
  assign unused_fault_s = &{1'b0, i_pgfault_n, i_vstb, i_vaddr, i_fault_clr};
  assign o_fault      = 1'b0;
  assign o_fault_page = 3'd0;
  assign o_fault_ctx  = {CTXW{1'b0}};
`endif

endmodule

// File: tb/tb_mmu_ctxload.sv
// Randomized self-checking bench for mmu_ctxload against a shadow-array reference model.
// Fault-capture checks follow MMU_CTXLOAD_FAULTCAP_EN.
module tb_mmu_ctxload;
  localparam int CTXW = 2;

  logic            clk = 1'b0;
  logic            i_reset = 1'b0;
  logic            i_we = 1'b0;
  logic [4:0]      i_waddr = 5'd0;
  logic [7:0]      i_wdata = 8'h00;
  logic            o_werr;
  logic            i_start = 1'b0;
  logic [1:0]      i_ctx = 2'd0;
  logic            o_busy, o_done, o_pte_we;
  logic [1:0]      o_cur_ctx;
  logic [2:0]      o_pte_idx;
  logic [7:0]      o_pte_data;
  logic            i_pte_ack = 1'b0;
  logic            i_pgfault_n = 1'b1;
  logic            i_vstb = 1'b0;
  logic [2:0]      i_vaddr = 3'd0;
  logic            i_fault_clr = 1'b0;
  logic            o_fault;
  logic [2:0]      o_fault_page;
  logic [1:0]      o_fault_ctx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] shadow_m [0:31];
  logic [1:0] cur_m;
  logic       fault_m;
  logic [2:0] fpage_m;
  logic [1:0] fctx_m;

  always #5 clk = ~clk;

  mmu_ctxload #(.CTXW(CTXW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata),
    .o_werr(o_werr), .i_start(i_start), .i_ctx(i_ctx), .o_busy(o_busy), .o_done(o_done),
    .o_cur_ctx(o_cur_ctx), .o_pte_we(o_pte_we), .o_pte_idx(o_pte_idx), .o_pte_data(o_pte_data),
    .i_pte_ack(i_pte_ack), .i_pgfault_n(i_pgfault_n), .i_vstb(i_vstb), .i_vaddr(i_vaddr),
    .i_fault_clr(i_fault_clr), .o_fault(o_fault), .o_fault_page(o_fault_page),
    .o_fault_ctx(o_fault_ctx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    #2;
    check("rst_pte_we", o_pte_we, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_werr", o_werr, 1'b0);
    check("rst_cur_ctx", o_cur_ctx, 2'd0);
    check("rst_pte_idx", o_pte_idx, 3'd0);
    check("rst_pte_data", o_pte_data, 8'h00);
    check("rst_fault", o_fault, 1'b0);
    i_reset = 1'b0;
    for (int i = 0; i < 32; i++) shadow_m[i] = 8'h00;
    cur_m   = 2'd0;
    fault_m = 1'b0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [7:0] data);
    i_we = 1'b1;
    i_waddr = addr;
    i_wdata = data;
    step();
    i_we = 1'b0;
    shadow_m[addr] = data;
    check("werr_idle", o_werr, 1'b0);
  endtask

  // mode 0: ack always high; 1: ack low stall_len cycles at stall_idx; 2: random ack and noise
  task automatic run_load(input logic [1:0] ctx, input int mode, input int stall_idx,
                          input int stall_len, input int inj_cyc, input int abort_idx);
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    logic a, w;
    logic [2:0] kk;
    i_ctx = ctx;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_ctx = 2'($urandom);
    check("start_pte_we", o_pte_we, 1'b1);
    check("start_pte_idx", o_pte_idx, 3'd0);
    check("start_pte_data", o_pte_data, shadow_m[{ctx, 3'd0}]);
    check("start_busy", o_busy, 1'b1);
    while (k < 8 && cyc < 200) begin
      if (k == abort_idx) begin
        do_reset();
        i_pte_ack = 1'b0;
        return;
      end
      a = 1'b1;
      if (mode == 1 && k == stall_idx && stalls < stall_len) begin
        a = 1'b0;
        stalls++;
      end
      if (mode == 2) a = 1'($urandom_range(0, 1));
      i_pte_ack = a;
      i_we = 1'b0;
      i_start = 1'b0;
      if (cyc == inj_cyc) begin
        i_we = 1'b1;
        i_waddr = {ctx, 3'd0};
        i_wdata = 8'h99;
        i_start = 1'b1;
        i_ctx = ctx + 2'd1;
      end
      if (mode == 2) begin
        i_we = 1'($urandom_range(0, 1));
        i_waddr = 5'($urandom);
        i_wdata = 8'($urandom);
        i_start = 1'($urandom_range(0, 1));
        i_ctx = 2'($urandom);
      end
      w = i_we;
      step();
      cyc++;
      if (a) k++;
      i_we = 1'b0;
      i_start = 1'b0;
      check("load_werr", o_werr, w);
      check("load_busy", o_busy, 1'b1);
      if (k < 8) begin
        kk = 3'(k);
        check("load_pte_we", o_pte_we, 1'b1);
        check("load_pte_idx", o_pte_idx, kk);
        check("load_pte_data", o_pte_data, shadow_m[{ctx, kk}]);
        check("load_done_early", o_done, 1'b0);
        check("load_cur_ctx", o_cur_ctx, cur_m);
      end else begin
        cur_m = ctx;
        check("done_pte_we", o_pte_we, 1'b0);
        check("done_pulse", o_done, 1'b1);
        check("done_cur_ctx", o_cur_ctx, cur_m);
      end
    end
    if (k < 8) begin
      check("load_timeout", 32'(k), 32'd8);
      i_pte_ack = 1'b0;
      return;
    end
    i_pte_ack = 1'($urandom_range(0, 1));
    step();
    i_pte_ack = 1'b0;
    check("idle_done", o_done, 1'b0);
    check("idle_busy", o_busy, 1'b0);
    check("idle_pte_we", o_pte_we, 1'b0);
    check("idle_cur_ctx", o_cur_ctx, cur_m);
    check("idle_werr", o_werr, 1'b0);
  endtask

  task automatic fault_cycle(input logic vstb, input logic pgn, input logic [2:0] va,
                             input logic clr);
    i_vstb = vstb;
    i_pgfault_n = pgn;
    i_vaddr = va;
    i_fault_clr = clr;
    step();
    i_vstb = 1'b0;
    i_pgfault_n = 1'b1;
    i_fault_clr = 1'b0;
`ifdef MMU_CTXLOAD_FAULTCAP_EN
    if (fault_m && clr) fault_m = 1'b0;
    else if (!fault_m && vstb && !pgn) begin
      fault_m = 1'b1;
      fpage_m = va;
      fctx_m  = cur_m;
    end
    check("fault_flag", o_fault, fault_m);
    if (fault_m) begin
      check("fault_page", o_fault_page, fpage_m);
      check("fault_ctx", o_fault_ctx, fctx_m);
    end
`else
    check("fault_flag_off", o_fault, 1'b0);
    check("fault_page_off", o_fault_page, 3'd0);
    check("fault_ctx_off", o_fault_ctx, 2'd0);
`endif
  endtask

  logic [7:0] tbl [0:7];

  initial begin
    tbl = '{8'h80, 8'h82, 8'h83, 8'h84, 8'h8c, 8'h8d, 8'h0e, 8'h8f};
    fpage_m = 3'd0;
    fctx_m = 2'd0;
    #1;
    do_reset();

    run_load(2'd1, 0, 0, 0, -1, 8);
    for (int i = 0; i < 8; i++) wr({2'd2, 3'(i)}, tbl[i]);
    run_load(2'd2, 0, 0, 0, -1, 8);
    run_load(2'd2, 1, 4, 3, -1, 8);
    run_load(2'd2, 0, 0, 0, 2, 8);
    run_load(2'd2, 0, 0, 0, -1, 8);
    check("entry_2_0", shadow_m[{2'd2, 3'd0}], 8'h80);

    run_load(2'd2, 0, 0, 0, -1, 5);
    run_load(2'd2, 0, 0, 0, -1, 8);

    for (int i = 0; i < 8; i++) wr({2'd2, 3'(i)}, tbl[i]);
    run_load(2'd2, 0, 0, 0, -1, 8);
    fault_cycle(1'b1, 1'b0, 3'd6, 1'b0);
    fault_cycle(1'b1, 1'b0, 3'd3, 1'b0);
    fault_cycle(1'b0, 1'b1, 3'd0, 1'b1);
    fault_cycle(1'b1, 1'b0, 3'd5, 1'b1);
    fault_cycle(1'b1, 1'b0, 3'd1, 1'b1);
    fault_cycle(1'b0, 1'b0, 3'd2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      fault_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom),
                  1'($urandom_range(0, 1)));
    end

    for (int r = 0; r < 20; r++) begin
      int nw;
      nw = int'($urandom_range(0, 4));
      for (int j = 0; j < nw; j++) wr(5'($urandom), 8'($urandom));
      run_load(2'($urandom), 2, 0, 0, -1, 8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
